// File: rtl/aes_key_sched_seq.sv
// AES-128/192/256 key schedule: one expanded word per cycle, round keys 0..Nr on a valid/ready stream; AES_KEY_SCHED_RKBUF_EN adds a read-back buffer.
// First round key valid 4 cycles after start; a pending key with rk_ready low freezes the whole generator.
module aes_key_sched_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                abort,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                busy,
  output logic                done,
  input  logic [3:0]          rd_idx,
  output logic [127:0]        rd_key
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [2:0] KPOS_MAX = 3'(NK - 1);
  localparam logic [3:0] NR_IDX   = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_sched_seq: KEY_BITS must be 128, 192 or 256");
  end

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          kpos_q, kpos_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [95:0]         asm_q, asm_d;
  logic                rk_valid_q, rk_valid_d;
  logic [127:0]        rk_data_q, rk_data_d;
  logic [3:0]          rk_idx_q, rk_idx_d;

  logic [31:0] w_old, w_prev, w_new;
  logic        start_ok, advance, xfer;

  // Window holds w[i-Nk] (top word) .. w[i-1] (bottom word); the key words rotate through it first.
  assign w_old  = win_q[KEY_BITS-1 -: 32];
  assign w_prev = win_q[31:0];

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign advance  = (state_q == S_GEN) && (cnt_q <= LAST_W) && !(rk_valid_q && !rk_ready);
  assign xfer     = rk_valid_q && rk_ready && !abort;

  always_comb begin
    if (cnt_q < NK_W) begin
      w_new = w_old;
    end else if (kpos_q == 3'd0) begin
      w_new = w_old ^ sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
    end else if (NK == 8 && kpos_q == 3'd4) begin
      w_new = w_old ^ sub_word(w_prev);
    end else begin
      w_new = w_old ^ w_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_GEN;
        S_GEN:          if (xfer && rk_idx_q == NR_IDX) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == S_GEN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    win_d      = win_q;
    cnt_d      = cnt_q;
    kpos_d     = kpos_q;
    rcon_d     = rcon_q;
    asm_d      = asm_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    if (abort) begin
      rk_valid_d = 1'b0;
    end else if (start_ok) begin
      win_d      = key_in;
      cnt_d      = 6'd0;
      kpos_d     = 3'd0;
      rcon_d     = 8'h01;
      rk_valid_d = 1'b0;
    end else begin
      if (xfer) rk_valid_d = 1'b0;
      if (advance) begin
        win_d  = {win_q[KEY_BITS-33:0], w_new};
        cnt_d  = cnt_q + 6'd1;
        kpos_d = (kpos_q == KPOS_MAX) ? 3'd0 : kpos_q + 3'd1;
        if (cnt_q >= NK_W && kpos_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        asm_d = {asm_q[63:0], w_new};
        if (cnt_q[1:0] == 2'b11) begin
          rk_data_d  = {asm_q, w_new};
          rk_idx_d   = cnt_q[5:2];
          rk_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      cnt_q      <= '0;
      kpos_q     <= '0;
      rcon_q     <= '0;
      asm_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
    end else begin
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      kpos_q     <= kpos_d;
      rcon_q     <= rcon_d;
      asm_q      <= asm_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;

`ifdef AES_KEY_SCHED_RKBUF_EN
  logic [127:0] rkbuf_q [NR+1];
  logic [127:0] rd_key_q;

  always_ff @(posedge clk) begin
    if (xfer) rkbuf_q[rk_idx_q] <= rk_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= '0;
    end else begin
      rd_key_q <= (rd_idx <= NR_IDX) ? rkbuf_q[rd_idx] : '0;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboard bench for aes_key_sched_seq: one instance per key size, expected round keys queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_aes_key_sched_seq;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    bit           chk;
  } exp_t;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY_192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] r128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, abort, rk_ready;
  logic [3:0]   rd_idx;
  logic         start_w [3];
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         rk_valid_w [3];
  logic [127:0] rk_data_w [3];
  logic [3:0]   rk_idx_w [3];
  logic         busy_w [3];
  logic         done_w [3];
  logic [127:0] rd_key_w [3];

  aes_key_sched_seq #(.KEY_BITS(128)) u_k128 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .key_in(key128), .abort(abort),
    .rk_valid(rk_valid_w[0]), .rk_ready(rk_ready), .rk_data(rk_data_w[0]), .rk_idx(rk_idx_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rd_idx(rd_idx), .rd_key(rd_key_w[0]));

  aes_key_sched_seq #(.KEY_BITS(192)) u_k192 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .key_in(key192), .abort(abort),
    .rk_valid(rk_valid_w[1]), .rk_ready(rk_ready), .rk_data(rk_data_w[1]), .rk_idx(rk_idx_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .rd_idx(rd_idx), .rd_key(rd_key_w[1]));

  aes_key_sched_seq #(.KEY_BITS(256)) u_k256 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .key_in(key256), .abort(abort),
    .rk_valid(rk_valid_w[2]), .rk_ready(rk_ready), .rk_data(rk_data_w[2]), .rk_idx(rk_idx_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .rd_idx(rd_idx), .rd_key(rd_key_w[2]));

  logic [1:0]   sel;
  logic         mon_valid, mon_busy, mon_done;
  logic [3:0]   mon_idx;
  logic [127:0] mon_data, mon_rd;

  always_comb begin
    case (sel)
      2'd1: begin
        mon_valid = rk_valid_w[1]; mon_data = rk_data_w[1]; mon_idx = rk_idx_w[1];
        mon_busy = busy_w[1]; mon_done = done_w[1]; mon_rd = rd_key_w[1];
      end
      2'd2: begin
        mon_valid = rk_valid_w[2]; mon_data = rk_data_w[2]; mon_idx = rk_idx_w[2];
        mon_busy = busy_w[2]; mon_done = done_w[2]; mon_rd = rd_key_w[2];
      end
      default: begin
        mon_valid = rk_valid_w[0]; mon_data = rk_data_w[0]; mon_idx = rk_idx_w[0];
        mon_busy = busy_w[0]; mon_done = done_w[0]; mon_rd = rd_key_w[0];
      end
    endcase
  end

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0 = 0;
  exp_t sb_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic [127:0] data, input bit c);
    exp_t e;
    e.idx = idx; e.data = data; e.chk = c;
    sb_q.push_back(e);
  endtask

  task automatic push_idx_only(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) push(4'(r), 128'h0, 1'b0);
  endtask

  // Monitor: pops one expected key per accepted transfer and checks stall stability.
  exp_t         mon_e;
  bit           stall_prev = 1'b0;
  logic [127:0] stall_data;
  logic [3:0]   stall_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mon_valid && rk_ready && !abort) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got round %0d data %h, required no key", mon_idx, mon_data);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_idx !== mon_e.idx || (mon_e.chk && mon_data !== mon_e.data)) begin
            n_fail++;
            $display("FAIL sb_round: got idx %0d data %h, required idx %0d data %h (data checked %0d)",
                     mon_idx, mon_data, mon_e.idx, mon_e.data, mon_e.chk);
          end
        end
      end
      if (stall_prev) begin
        n_checks++;
        if (!mon_valid || mon_data !== stall_data || mon_idx !== stall_idx) begin
          n_fail++;
          $display("FAIL stall_hold: got valid %0b idx %0d data %h, required valid 1 idx %0d data %h",
                   mon_valid, mon_idx, mon_data, stall_idx, stall_data);
        end
      end
      stall_prev = mon_valid && !rk_ready && !abort;
      stall_data = mon_data;
      stall_idx  = mon_idx;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_start(input logic [1:0] s);
    sel = s;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    start_w[s] = 1'b1;
    @(posedge clk); #1;
    start_w[s] = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 128'(mon_busy), 128'(1));
  endtask

  task automatic wait_done(input int exp_cyc, input bit rnd, input string tag);
    int stalls = 0;
    while (!mon_done && (cyc - t0) < 400) begin
      rk_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (mon_valid && !rk_ready) stalls++;
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    chk({tag, "_done_cycles"}, 128'(cyc - t0), 128'(exp_cyc + stalls));
    chk({tag, "_sb_drained"}, 128'(sb_q.size()), 128'(0));
  endtask

  task automatic wait_idx(input logic [3:0] target, input string tag);
    int k = 0;
    while (!(mon_valid && mon_idx == target) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL %s: got no round %0d within 200 cycles, required it to appear", tag, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary within 200 us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; abort = 1'b0; rk_ready = 1'b1; rd_idx = 4'd0; sel = 2'd0;
    start_w[0] = 1'b0; start_w[1] = 1'b0; start_w[2] = 1'b0;
    key128 = KEY_A; key192 = KEY_192; key256 = KEY_256;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_rk_valid", 128'(mon_valid), 128'(0));
    chk("rst_rk_data", mon_data, 128'h0);
    chk("rst_rk_idx", 128'(mon_idx), 128'(0));
    chk("rst_busy", 128'(mon_busy), 128'(0));
    chk("rst_done", 128'(mon_done), 128'(0));
    chk("rst_rd_key", mon_rd, 128'h0);
    rst_n = 1'b1;

    // AES-128, consumer always ready
    for (int r = 0; r < 11; r++) push(4'(r), r128[r], 1'b1);
    do_start(2'd0);
    wait_done(45, 1'b0, "aes128");

`ifdef AES_KEY_SCHED_RKBUF_EN
    rd_idx = 4'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rkbuf_rd10", mon_rd, r128[10]);
    rd_idx = 4'd12;
    @(posedge clk); #1;
    chk("rkbuf_rd12", mon_rd, 128'h0);
    rd_idx = 4'd1;
    @(posedge clk); #1;
    chk("rkbuf_rd1", mon_rd, r128[1]);
`else
    rd_idx = 4'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd_key_off", mon_rd, 128'h0);
`endif
    rd_idx = 4'd0;

    // AES-192
    push(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1);
    push_idx_only(1, 11);
    push(4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
    do_start(2'd1);
    wait_done(53, 1'b0, "aes192");

    // AES-256
    push(4'd0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1);
    push(4'd1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b1);
    push_idx_only(2, 13);
    push(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
    do_start(2'd2);
    wait_done(61, 1'b0, "aes256");

    // AES-128 with a randomly stalling consumer
    key128 = KEY_A;
    for (int r = 0; r < 11; r++) push(4'(r), r128[r], 1'b1);
    do_start(2'd0);
    wait_done(45, 1'b1, "aes128_stall");

    // start while generating is ignored
    key128 = KEY_A;
    for (int r = 0; r < 11; r++) push(4'(r), r128[r], 1'b1);
    do_start(2'd0);
    wait_idx(4'd3, "start_ign_wait");
    key128 = KEY_B;
    start_w[0] = 1'b1;
    @(posedge clk); #1;
    start_w[0] = 1'b0;
    wait_done(45, 1'b0, "start_ignored");

    // abort at round 5, then restart with a new key
    key128 = KEY_A;
    for (int r = 0; r < 5; r++) push(4'(r), r128[r], 1'b1);
    do_start(2'd0);
    wait_idx(4'd5, "abort_wait");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_rk_valid", 128'(mon_valid), 128'(0));
    chk("abort_busy", 128'(mon_busy), 128'(0));
    chk("abort_done", 128'(mon_done), 128'(0));
    chk("abort_sb", 128'(sb_q.size()), 128'(0));
    key128 = KEY_B;
    push(4'd0, KEY_B, 1'b1);
    push_idx_only(1, 10);
    do_start(2'd0);
    wait_done(45, 1'b0, "abort_restart");

    // asynchronous reset mid-generation
    key128 = KEY_A;
    push(4'd0, r128[0], 1'b1);
    push(4'd1, r128[1], 1'b1);
    do_start(2'd0);
    wait_idx(4'd2, "reset_wait");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rk_valid", 128'(mon_valid), 128'(0));
    chk("arst_rk_data", mon_data, 128'h0);
    chk("arst_rk_idx", 128'(mon_idx), 128'(0));
    chk("arst_busy", 128'(mon_busy), 128'(0));
    chk("arst_done", 128'(mon_done), 128'(0));
    chk("arst_sb", 128'(sb_q.size()), 128'(0));
    #3 rst_n = 1'b1;
    key128 = KEY_B;
    push(4'd0, KEY_B, 1'b1);
    push_idx_only(1, 10);
    do_start(2'd0);
    wait_done(45, 1'b0, "reset_restart");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Sequential, parametrised AES key-schedule engine. It accepts one cipher key of 128, 192 or 256 bits and generates the expanded key one 32-bit word per cycle. It emits each completed 128-bit round key over a valid/ready stream, in round order 0..Nr. It sits between key load and the round datapath, replacing the fixed, combinational 128-bit key combiner with a single generator that serves all three key sizes and can stall.

## Interface
- KEY_BITS, 128, cipher key width; legal values are 128, 192 and 256, and any other value is an elaboration error.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin expansion of key_in; honoured only in IDLE or DONE.
- key_in  in  KEY_BITS  cipher key, MSB-first: w0 = key_in[KEY_BITS-1 -: 32]; sampled only on an accepted start.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- rk_valid  out  1  rk_data/rk_idx hold a round key.
- rk_ready  in  1  consumer accepts the round key on the cycle it is high with rk_valid.
- rk_data  out  128  round key, MSB = first word of the round.
- rk_idx  out  4  round number 0..Nr.
- busy  out  1  high in GEN.
- done  out  1  high in DONE, after the last round key has been accepted.
- rd_idx  in  4  buffer read index (see Configuration).
- rd_key  out  128  buffer read data (see Configuration).

## Operation
- Derived constants: Nk = KEY_BITS/32, Nr = Nk+6, total words W = 4*(Nr+1), giving 44, 52 or 60.
- **States:** IDLE, GEN, DONE.
- **IDLE/DONE:**
  - On start, latch key_in into an Nk-word sliding window and clear the word counter i to 0.
  - Set rcon = 0x01 and enter GEN.
  - Clear done on leaving DONE.
- **GEN:** each advancing cycle produces word w[i].
  - For i < Nk, w[i] = key word i.
  - For i ≥ Nk, w[i] = w[i-Nk] ^ t, where t depends on i:
    - i%Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon), reducing modulo 0x11B.
    - Nk == 8 and i%Nk == 4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - w[i] shifts into the window and into a 4-word assembly register.
  - When i%4 == 3, the assembled 128 bits load rk_data, rk_idx = i/4, and rk_valid = 1.
  - When i == W-1 and that key is accepted, go to DONE.
- **Stall:** GEN does not advance while rk_valid && !rk_ready. The counter, window, rcon and assembly register all hold.
- **Output handshake:**
  - A transfer occurs on rk_valid && rk_ready.
  - rk_valid drops the cycle after the transfer unless a new key loads on that same edge.
  - rk_data and rk_idx are stable while rk_valid && !rk_ready.
- **start while busy (GEN):** ignored; no state change.
- **abort:** has priority over start and over the handshake. Next cycle the block is in IDLE with rk_valid = 0, busy = 0, done = 0.
- **SubWord:** four combinational S-box lookups, per FIPS-197.

## Timing
- **Reset values:** rk_valid = 0, rk_data = 0, rk_idx = 0, busy = 0, done = 0, rd_key = 0. State is IDLE.
- **Start to first key:** start accepted at edge 0; busy is high from cycle 1. w0..w3 are produced on the following 4 edges, so rk_valid (round 0) is high after edge 4.
- **Throughput:** with rk_ready held high, one round key every 4 cycles.
  - Last key becomes valid after edge W.
  - done is high after edge W+1: 45, 53 or 61 cycles after start.
- **Stall cost:** each cycle of rk_valid && !rk_ready adds exactly one cycle.
- **Reset mid-expansion:** the state and all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- AES_KEY_SCHED_RKBUF_EN
  - **Defined:** each transferred round key is also written to an internal (Nr+1)x128 buffer at rk_idx. rd_key = buffer[rd_idx], registered with 1-cycle latency. An rd_idx greater than Nr returns 0. This supports reverse-order key reads for decryption.
  - **Undefined:** no buffer; rd_key is constant 0 and rd_idx is ignored.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done 45 cycles after start.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: 13 keys; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: 15 keys; round 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with rk_ready randomly low about 50% of cycles:
  - identical key sequence; rk_data stable while stalled.
  - done at 45 + stall cycles.
- Mid-run events:
  - start asserted at round 3 is ignored.
  - abort at round 5 gives IDLE next cycle with rk_valid = 0.
  - rst_n pulsed low mid-GEN clears all outputs asynchronously.
  - A new start after any of these reproduces round 0 of the new key.
- With AES_KEY_SCHED_RKBUF_EN, after the AES-128 run:
  - rd_idx = 10 gives rd_key = d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later.
  - rd_idx = 12 gives 0.
